cam_capture: RTL

Frame-capture stage between the OV7670 camera port and `buffer_ram`. On request it waits for a frame start, assembles RGB565 byte pairs into 3-bit RGB111 pixels and issues one write per pixel into the frame buffer. When the frame ends it raises `read` so `colors` can scan the stored image. The result is held for as long as the request stays high, for example while `car_stop` is asserted.

---
 rtl/cam_pkg.sv | 20 ++
 rtl/cam_capture_if.sv | 12 +
 rtl/cam_capture_pixel_pack.sv | 49 ++++
 rtl/cam_capture.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/cam_pkg.sv
// Shared types and constants for the camera capture path.
// Bit positions select the MSB of each RGB565 channel inside the two camera bytes.
package cam_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_VS = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } cap_state_t;

    localparam int H_PIXELS_DEF = 160;
    localparam int V_LINES_DEF  = 120;

    // R[4:0]=A[7:3], G[5:0]={A[2:0],B[7:5]}, B[4:0]=B[4:0]
    localparam int R_MSB = 7;
    localparam int G_MSB = 2;
    localparam int B_MSB = 4;

endpackage

// File: rtl/cam_capture_if.sv
// Frame-buffer write port: the capture stage drives it, buffer_ram consumes it.
interface cam_capture_if #(
    parameter int AW = 15,
    parameter int DW = 3
);
    logic          regwrite;
    logic [DW-1:0] data_w;
    logic [AW-1:0] addr;

    modport master (output regwrite, output data_w, output addr);
    modport slave  (input  regwrite, input  data_w, input  addr);
endinterface

// File: rtl/cam_capture_pixel_pack.sv
// Pairs camera bytes (A then B) of a line and reduces RGB565 to RGB111.
module pixel_pack
    import cam_pkg::*;
#(
    parameter int DW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          href_s1,
    input  logic          href_rise,
    input  logic [7:0]    d_s1,
    output logic          pix_valid,
    output logic [DW-1:0] pix
);
    logic       phase_r;
    logic       phase_s;
    logic [7:0] byte_a_r;
    logic       unused_s;

    // first byte of every line is always byte A, whatever phase the last line left
    always_comb begin
        phase_s = 1'b0;
        if (href_rise) begin
            phase_s = 1'b0;
        end else begin
            phase_s = phase_r;
        end
        pix_valid = href_s1 & phase_s;
        pix       = DW'({byte_a_r[R_MSB], byte_a_r[G_MSB], d_s1[B_MSB]});
    end

    // byte phase toggles on every valid byte; byte A is held for its partner
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_r  <= 1'b0;
            byte_a_r <= 8'h00;
        end else if (clear) begin
            phase_r  <= 1'b0;
        end else if (href_s1) begin
            phase_r <= ~phase_s;
            if (!phase_s) begin
                byte_a_r <= d_s1;
            end
        end
    end

    assign unused_s = ^byte_a_r;
endmodule

// File: rtl/cam_capture.sv
// Frame capture: waits for a frame start, writes one RGB111 pixel per byte pair
// into the frame buffer and holds `read` while the request stays high.
module cam_capture
    import cam_pkg::*;
#(
    parameter int AW       = 15,
    parameter int DW       = 3,
    parameter int H_PIXELS = H_PIXELS_DEF,
    parameter int V_LINES  = V_LINES_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          capture_req,
    input  logic          VSYNC,
    input  logic          HREF,
    input  logic [7:0]    D,
    cam_capture_if.master wr,
    output logic          read,
    output logic          frame_done,
    output logic          overflow
);
    localparam int CW = $clog2(H_PIXELS + 1);
    localparam int LW = $clog2(V_LINES + 1);
    localparam logic [CW-1:0] H_MAX    = CW'(H_PIXELS);
    localparam logic [LW-1:0] V_MAX    = LW'(V_LINES);
    localparam logic [AW-1:0] ROW_STEP = AW'(H_PIXELS);

    logic          vsync_s1_r, href_s1_r, vsync_d_r, href_d_r;
    logic [7:0]    d_s1_r;
    logic          vs_rise_s, vs_fall_s, href_rise_s, href_fall_s;
    cap_state_t    state_r, state_s;
    logic [CW-1:0] col_r;
    logic [LW-1:0] line_r;
    logic [AW-1:0] row_base_r;
    logic          frame_start_s, capturing_s, in_range_s, write_s, drop_s;
    logic          pix_valid_s;
    logic [DW-1:0] pix_s;
    logic          regwrite_r, read_r, frame_done_r, overflow_r;
    logic [DW-1:0] data_w_r;
    logic [AW-1:0] addr_r;

    // camera pins are sampled once; edges compare this sample with the previous one
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vsync_s1_r <= 1'b0;
            href_s1_r  <= 1'b0;
            d_s1_r     <= 8'h00;
            vsync_d_r  <= 1'b0;
            href_d_r   <= 1'b0;
        end else begin
            vsync_s1_r <= VSYNC;
            href_s1_r  <= HREF;
            d_s1_r     <= D;
            vsync_d_r  <= vsync_s1_r;
            href_d_r   <= href_s1_r;
        end
    end

    assign vs_rise_s   = vsync_s1_r & ~vsync_d_r;
    assign vs_fall_s   = ~vsync_s1_r & vsync_d_r;
    assign href_rise_s = href_s1_r & ~href_d_r;
    assign href_fall_s = ~href_s1_r & href_d_r;

    pixel_pack #(.DW(DW)) u_pack (
        .clk       (clk),
        .rst       (rst),
        .clear     (frame_start_s),
        .href_s1   (href_s1_r),
        .href_rise (href_rise_s),
        .d_s1      (d_s1_r),
        .pix_valid (pix_valid_s),
        .pix       (pix_s)
    );

    // a dropped request aborts the frame and wins over any VSYNC event
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (capture_req) state_s = WAIT_VS;
                else             state_s = IDLE;
            end
            WAIT_VS: begin
                if (!capture_req)   state_s = IDLE;
                else if (vs_fall_s) state_s = CAPTURE;
                else                state_s = WAIT_VS;
            end
            CAPTURE: begin
                if (!capture_req)   state_s = IDLE;
                else if (vs_rise_s) state_s = DONE;
                else                state_s = CAPTURE;
            end
            DONE: begin
                if (!capture_req) state_s = IDLE;
                else              state_s = DONE;
            end
            default: state_s = IDLE;
        endcase
    end

    assign frame_start_s = (state_r == WAIT_VS) & capture_req & vs_fall_s;
    assign capturing_s   = (state_r == CAPTURE) & capture_req;
    assign in_range_s    = (col_r < H_MAX) & (line_r < V_MAX);
    assign write_s       = capturing_s & pix_valid_s & in_range_s;
    assign drop_s        = capturing_s & pix_valid_s & ~in_range_s;

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_r <= IDLE;
        else     state_r <= state_s;
    end

    // column/line counters saturate; row_base replaces line*H_PIXELS
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_r      <= '0;
            line_r     <= '0;
            row_base_r <= '0;
        end else if (frame_start_s) begin
            col_r      <= '0;
            line_r     <= '0;
            row_base_r <= '0;
        end else if (state_r == CAPTURE) begin
            if (href_rise_s) begin
                col_r <= '0;
            end else if (pix_valid_s && (col_r != H_MAX)) begin
                col_r <= col_r + CW'(1);
            end
            if (href_fall_s && (line_r != V_MAX)) begin
                line_r     <= line_r + LW'(1);
                row_base_r <= row_base_r + ROW_STEP;
            end
        end
    end

    // registered buffer strobe and status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regwrite_r   <= 1'b0;
            data_w_r     <= '0;
            addr_r       <= '0;
            read_r       <= 1'b0;
            frame_done_r <= 1'b0;
            overflow_r   <= 1'b0;
        end else begin
            regwrite_r   <= write_s;
            read_r       <= (state_s == DONE);
            frame_done_r <= capturing_s & vs_rise_s;
            if (write_s) begin
                data_w_r <= pix_s;
                addr_r   <= row_base_r + AW'(col_r);
            end
            if (frame_start_s) overflow_r <= 1'b0;
            else if (drop_s)   overflow_r <= 1'b1;
        end
    end

    assign wr.regwrite = regwrite_r;
    assign wr.data_w   = data_w_r;
    assign wr.addr     = addr_r;
    assign read        = read_r;
    assign frame_done  = frame_done_r;
    assign overflow    = overflow_r;
endmodule
